// File: rtl/sobel_frame_controller.sv
// -----------------------------------------------------------------------------
// sobel_frame_controller
//
// Frame-level sequencer between the UART receive byte stream and the Sobel
// datapath. It parses a 4-byte little-endian header (width, height), checks the
// dimensions and publishes them as configuration. It then forwards pixel bytes
// through a one-entry holding register, appends one all-zero flush row, counts
// datapath outputs to detect frame completion, and aborts the frame on bad
// dimensions, receive overrun or a stall timeout.
//
// Ports
//   clk_a                  clock, all logic on its rising edge
//   rst                    synchronous, active-high reset
//   rx_data / rx_valid     received byte and its single-cycle strobe
//   pix_data / pix_valid   holding register towards the datapath
//   pix_ready              datapath accepts (transfer on pix_valid && pix_ready)
//   pix_flush              pix_data is a synthetic flush byte
//   dp_valid               datapath output strobe, one per output pixel
//   cfg_width/cfg_height   validated dimensions, held until the next cfg_valid
//   cfg_valid              one-cycle pulse: new configuration
//   dp_rst                 datapath reset request
//   busy                   high whenever the sequencer is not idle
//   frame_done, err_dim,
//   err_timeout, err_overrun  one-cycle status pulses
// -----------------------------------------------------------------------------
module sobel_frame_controller #(
   parameter int DATA_BITS      = 8,
   parameter int MAX_WIDTH      = 1024,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clk_a,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] rx_data,
   input  logic                 rx_valid,
   output logic [DATA_BITS-1:0] pix_data,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic                 pix_flush,
   input  logic                 dp_valid,
   output logic [15:0]          cfg_width,
   output logic [15:0]          cfg_height,
   output logic                 cfg_valid,
   output logic                 dp_rst,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 err_dim,
   output logic                 err_timeout,
   output logic                 err_overrun
);

   localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_CHECK, S_STREAM, S_FLUSH, S_DRAIN, S_DONE, S_ERR
   } state_t;

   state_t state, next_state;

   logic [1:0]       hdr_cnt;
   logic [15:0]      hdr_width, hdr_height;
   logic [31:0]      pix_total, in_cnt, out_cnt;
   logic [15:0]      fl_cnt;
   logic [TMO_W-1:0] tmo_cnt;

   logic dim_ok, drain, overrun, load_pix, load_flush;
   logic tmo_active, tmo_kick, tmo_hit;

   // Next values of the registered status outputs.
   logic cfg_valid_nxt, err_dim_nxt, err_overrun_nxt, err_timeout_nxt;
   logic frame_done_nxt, dp_rst_nxt, busy_nxt;

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   assign dim_ok = (hdr_width >= 16'd3) && (32'(hdr_width) <= 32'(MAX_WIDTH)) &&
                   (hdr_height >= 16'd2);

   assign drain = pix_valid && pix_ready;

   // A byte arriving while the register is full and not emptying this cycle
   // has nowhere to go: the source cannot be stalled.
   assign overrun  = (state == S_STREAM) && rx_valid && pix_valid && !pix_ready;
   assign load_pix = (state == S_STREAM) && rx_valid && !overrun;

   // Flush bytes enter only once the last real pixel has left (or is leaving).
   assign load_flush = (state == S_FLUSH) && (fl_cnt < cfg_width) &&
                       (!pix_valid || pix_ready);

   // Watchdog: any expected event in the current state restarts it.
   assign tmo_active = (state == S_HDR) || (state == S_STREAM) || (state == S_DRAIN);
   assign tmo_kick   = (((state == S_HDR) || (state == S_STREAM)) && rx_valid) ||
                       ((state == S_DRAIN) && dp_valid);
   assign tmo_hit    = tmo_active && !tmo_kick && (tmo_cnt == TMO_LAST);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_a) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assignment first, so no path through the case leaves
      // next_state unassigned and infers a latch.
      next_state = state;
      unique case (state)
         S_IDLE:   if (rx_valid) next_state = S_HDR;
         S_HDR: begin
            if (rx_valid && (hdr_cnt == 2'd3)) next_state = S_CHECK;
            else if (tmo_hit)                  next_state = S_ERR;
         end
         S_CHECK:  next_state = dim_ok ? S_STREAM : S_ERR;
         S_STREAM: begin
            if (overrun)                                          next_state = S_ERR;
            else if (load_pix && ((in_cnt + 32'd1) == pix_total)) next_state = S_FLUSH;
            else if (tmo_hit)                                     next_state = S_ERR;
         end
         // All flush bytes loaded and the last one is leaving.
         S_FLUSH:  if (drain && (fl_cnt == cfg_width)) next_state = S_DRAIN;
         S_DRAIN: begin
            if (out_cnt == pix_total) next_state = S_DONE;
            else if (tmo_hit)         next_state = S_ERR;
         end
         S_DONE:   next_state = S_IDLE;
         S_ERR:    next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic (values registered below, so pulses coincide with the
   // state they describe)
   // ---------------------------------------------------------------------------
   always_comb begin
      cfg_valid_nxt   = (state == S_CHECK) && dim_ok;
      err_dim_nxt     = (state == S_CHECK) && !dim_ok;
      err_overrun_nxt = overrun;
      err_timeout_nxt = tmo_hit && !overrun;
      frame_done_nxt  = (next_state == S_DONE);
      dp_rst_nxt      = (next_state == S_DONE) || (next_state == S_ERR);
      busy_nxt        = (next_state != S_IDLE);
   end

   always_ff @(posedge clk_a) begin
      if (rst) begin
         cfg_valid   <= 1'b0;
         err_dim     <= 1'b0;
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
         frame_done  <= 1'b0;
         dp_rst      <= 1'b1;
         busy        <= 1'b0;
      end else begin
         cfg_valid   <= cfg_valid_nxt;
         err_dim     <= err_dim_nxt;
         err_overrun <= err_overrun_nxt;
         err_timeout <= err_timeout_nxt;
         frame_done  <= frame_done_nxt;
         dp_rst      <= dp_rst_nxt;
         busy        <= busy_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Header capture and configuration
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_a) begin
      if (rst) begin
         hdr_cnt    <= 2'd0;
         hdr_width  <= 16'd0;
         hdr_height <= 16'd0;
      end else if (rx_valid) begin
         if (state == S_IDLE) begin
            hdr_width[7:0] <= rx_data[7:0];
            hdr_cnt        <= 2'd1;
         end else if (state == S_HDR) begin
            case (hdr_cnt)
               2'd1:    hdr_width[15:8]  <= rx_data[7:0];
               2'd2:    hdr_height[7:0]  <= rx_data[7:0];
               2'd3:    hdr_height[15:8] <= rx_data[7:0];
               default: ;
            endcase
            hdr_cnt <= hdr_cnt + 2'd1;
         end
      end
   end

   // Configuration survives an aborted frame; only a legal header replaces it.
   always_ff @(posedge clk_a) begin
      if (rst) begin
         cfg_width  <= 16'd0;
         cfg_height <= 16'd0;
         pix_total  <= 32'd0;
      end else if ((state == S_CHECK) && dim_ok) begin
         cfg_width  <= hdr_width;
         cfg_height <= hdr_height;
         pix_total  <= 32'(hdr_width) * 32'(hdr_height);
      end
   end

   // ---------------------------------------------------------------------------
   // Frame counters and watchdog
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_a) begin
      if (rst) begin
         in_cnt  <= 32'd0;
         out_cnt <= 32'd0;
         fl_cnt  <= 16'd0;
         tmo_cnt <= '0;
      end else begin
         if (state == S_CHECK) begin
            in_cnt  <= 32'd0;
            out_cnt <= 32'd0;
            fl_cnt  <= 16'd0;
         end
         if (load_pix)   in_cnt <= in_cnt + 32'd1;
         if (load_flush) fl_cnt <= fl_cnt + 16'd1;
         // The datapath may already emit outputs while pixels are still coming.
         if (dp_valid && ((state == S_STREAM) || (state == S_FLUSH) || (state == S_DRAIN)))
            out_cnt <= out_cnt + 32'd1;

         if (!tmo_active || tmo_kick || (next_state != state)) tmo_cnt <= '0;
         else                                                  tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // One-entry holding register towards the datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_a) begin
      // Any abort discards the byte in flight, including the one that overran.
      if (rst || (next_state == S_ERR)) begin
         pix_valid <= 1'b0;
         pix_data  <= '0;
         pix_flush <= 1'b0;
      end else if (load_pix) begin
         pix_valid <= 1'b1;
         pix_data  <= rx_data;
         pix_flush <= 1'b0;
      end else if (load_flush) begin
         pix_valid <= 1'b1;
         pix_data  <= '0;
         pix_flush <= 1'b1;
      end else if (drain) begin
         pix_valid <= 1'b0;
         pix_flush <= 1'b0;
      end
   end

endmodule

// File: doc/sobel_frame_controller.md
# sobel_frame_controller

Frame-level sequencer between the UART receive byte stream and the Sobel datapath. It parses the 4-byte frame header (width, height; 16-bit little-endian each), validates the dimensions and publishes them as configuration. It then forwards pixel bytes through a one-entry holding register and appends one synthetic all-zero flush row so the datapath emits its final output row. It counts datapath outputs to detect frame completion and aborts the frame on bad dimensions, receive overrun or stall timeout.

## Interface
- DATA_BITS, 8, pixel/byte width
- MAX_WIDTH, 1024, largest legal image width (line-buffer depth)
- TIMEOUT_CYCLES, 1000000, idle cycles tolerated between expected events
- clk_a  in  1  clock; all logic on posedge clk_a
- rst  in  1  reset, synchronous, active-high
- rx_data  in  DATA_BITS  received byte
- rx_valid  in  1  single-cycle strobe per byte; the source cannot stall
- pix_data  out  DATA_BITS  pixel to datapath
- pix_valid  out  1  holding register full
- pix_ready  in  1  datapath accepts; transfer when pix_valid && pix_ready
- pix_flush  out  1  current pix_data is a synthetic flush byte
- dp_valid  in  1  datapath output strobe (one per output pixel)
- cfg_width, cfg_height  out  16 each  validated dimensions, held until next cfg_valid
- cfg_valid  out  1  one-cycle pulse: new configuration
- dp_rst  out  1  datapath reset request
- busy  out  1  high in every state except IDLE
- frame_done, err_dim, err_timeout, err_overrun  out  1 each  one-cycle status pulses

## Operation
- States: IDLE, HDR, CHECK, STREAM, FLUSH, DRAIN, DONE, ERR.
- IDLE: rx_valid latches width[7:0], sets hdr_cnt=1 and goes to HDR.
- HDR: each rx_valid stores byte hdr_cnt (1: width[15:8], 2: height[7:0], 3: height[15:8]). After byte 3, go to CHECK.
- CHECK (one cycle):
  - Legal when 3 ≤ width ≤ MAX_WIDTH and height ≥ 2. Then load cfg_*, pulse cfg_valid, set pix_total = width*height (32-bit, unsigned) and go to STREAM.
  - Otherwise pulse err_dim and go to ERR.
- STREAM: rx_valid loads the holding register. in_cnt increments per loaded byte. When in_cnt reaches pix_total, go to FLUSH.
- Overrun: rx_valid while the register is full and not draining the same cycle. The byte is dropped, err_overrun pulses, and the block goes to ERR. Load and drain in the same cycle is legal.
- FLUSH: once the register drains, present pix_data=0 and pix_flush=1 for exactly width transfers, then go to DRAIN. rx_valid is ignored.
- DRAIN: out_cnt counts dp_valid in every state after CHECK. When out_cnt == pix_total, go to DONE. rx_valid is ignored.
- DONE: pulse frame_done, assert dp_rst, go to IDLE.
- ERR: assert dp_rst, clear the holding register, go to IDLE. cfg_* are retained.
- Timeout: tmo_cnt runs in HDR, STREAM and DRAIN. It clears on rx_valid in HDR/STREAM, on dp_valid in DRAIN, and on every state change. When it reaches TIMEOUT_CYCLES-1, pulse err_timeout and go to ERR. It is inactive in FLUSH.
- Error priority within a cycle: overrun > timeout.

## Timing
- Reset values: pix_valid=0, pix_data=0, pix_flush=0, cfg_width=cfg_height=0, cfg_valid=0, dp_rst=1, busy=0, all pulses 0, state IDLE, all counters 0.
- Reset mid-frame returns to IDLE within one cycle and discards the holding register contents.
- All outputs are registered.
- Header: last header byte sampled at edge N → CHECK at N+1 → cfg_valid high during cycle N+2, STREAM from N+2.
- Pixel latency: rx_valid sampled at edge k → pix_valid high from k+1 until the handshake edge.
- The flush stream runs back-to-back at one byte per cycle while pix_ready=1.
- Status pulses are exactly one cycle wide.
- dp_rst is high for exactly one cycle in DONE/ERR, plus the reset cycles.

## Test plan
- Legal 4x3 frame (header 04 00 03 00, 12 pixels), pix_ready=1, datapath returns 12 dp_valid → cfg_valid once with 4/3; 12 data transfers, then 4 transfers with pix_flush=1 and data 0; frame_done one cycle after the 12th dp_valid; dp_rst pulses.
- Header width=2 (02 00 05 00) → err_dim pulse two cycles after the last header byte; no pix_valid; back in IDLE; next legal frame completes.
- Header width=MAX_WIDTH+1 → err_dim. Width=MAX_WIDTH, height=2 → accepted, pix_total=2*MAX_WIDTH.
- pix_ready held low, two rx_valid bytes → second byte triggers err_overrun; ERR then IDLE. A load coinciding with a drain produces no error.
- TIMEOUT_CYCLES=16, header stops after 2 bytes → err_timeout 16 cycles after the last byte. The same stall in DRAIN also triggers err_timeout.
- rst asserted mid-STREAM → next cycle all outputs at reset values (dp_rst=1); a fresh frame afterwards completes normally.
